// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: memory depth,
// word geometry and the loader state encoding.
package instr_loader_pkg;

  localparam int DEPTH          = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_W         = 5;
  localparam int CNT_W          = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic count_legal(input logic [CNT_W-1:0] wc, input int depth);
    return (wc != '0) && (int'(wc) <= depth);
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Big-endian byte-to-word shifter: the first byte of a word ends up in [31:24].
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_complete
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_en) begin
      r_shift <= {r_shift[23:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // Word including the byte being accepted now, so the top can capture it on the 4th byte.
  assign o_word_next = {r_shift[23:0], i_byte};
  assign o_complete  = i_byte_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Streams program bytes into instruction memory, holding the CPU in reset until loaded.
//   state | meaning
//   IDLE  | waiting for Start, CPU held
//   RECV  | accepting bytes of the current word
//   WRITE | one-cycle memory write of the assembled word
//   DONE  | program loaded, CPU released
//   ERR   | Start rejected for an illegal WordCount
module instr_loader #(
  parameter int DEPTH = instr_loader_pkg::DEPTH
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Abort,
  input  logic [5:0]  WordCount,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        InstrWrEn,
  output logic [4:0]  InstrWrAddr,
  output logic [31:0] InstrWrData,
  output logic        CPUHold,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  import instr_loader_pkg::*;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_last, r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [31:0]       w_word_next;
  logic              w_complete, w_accept, w_launch, w_ready_state;

  assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_launch      = w_ready_state && Start && count_legal(WordCount, DEPTH);
  assign w_accept      = ByteValid && ByteReady;

  word_assembler u_asm (
    .i_clk       (Clk),
    .i_rst_n     (Reset),
    .i_clear     (w_launch),
    .i_byte_en   (w_accept),
    .i_byte      (ByteIn),
    .o_word_next (w_word_next),
    .o_complete  (w_complete)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ByteReady = 1'b0;
    InstrWrEn = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (Start) w_next = w_launch ? ST_RECV : ST_ERR;
      end
      ST_RECV: begin
        ByteReady = !Abort;
        if (Abort)           w_next = ST_IDLE;
        else if (w_complete) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (Abort) begin
          w_next = ST_IDLE;
        end else begin
          InstrWrEn = 1'b1;
          w_next    = (r_addr == r_last) ? ST_DONE : ST_RECV;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Write data/address are captured on entry to WRITE and then left alone.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_addr    <= '0;
      r_last    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_launch) begin
        r_addr <= '0;
        r_last <= ADDR_W'(WordCount - 6'd1);
      end
      if (w_complete) begin
        r_wr_data <= w_word_next;
        r_wr_addr <= r_addr;
      end
      if (r_state == ST_WRITE && !Abort && r_addr != r_last) r_addr <= r_addr + 1'b1;
    end
  end

  assign InstrWrAddr = r_wr_addr;
  assign InstrWrData = r_wr_data;
  assign CPUHold     = (r_state != ST_DONE);
  assign Done        = (r_state == ST_DONE);
  assign Busy        = (r_state == ST_RECV) || (r_state == ST_WRITE);
  assign Error       = (r_state == ST_ERR);

endmodule
